wt_dcache_rd_arb: RTL and testbench

// Shares the single dcache memory read port between NumPorts read controllers (load units, PTW, replay).

---
 rtl/wt_cache_pkg.sv | 19 +
 rtl/wt_dcache_rr_pick.sv | 29 ++
 rtl/wt_dcache_rd_arb.sv | 121 ++++++++++++
 tb/tb_wt_dcache_rd_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared dcache types and widths.
// Used by the dcache read-port arbiter and its round-robin picker.
package wt_cache_pkg;

    localparam int unsigned DCACHE_SET_ASSOC = 8;
    localparam int unsigned CL_IDX_W         = 8;
    localparam int unsigned OFFSET_W         = 4;
    localparam int unsigned TAG_W            = 20;

    localparam int unsigned RD_ARB_PORTS     = 3;
    localparam int unsigned RD_ARB_ID_W      = $clog2(RD_ARB_PORTS);

    typedef struct packed {
        logic                tag_only;
        logic [CL_IDX_W-1:0] idx;
        logic [OFFSET_W-1:0] off;
    } dcache_rd_req_t;

endpackage

// File: rtl/wt_dcache_rr_pick.sv
// Round-robin priority encoder.
// Picks the first set request at or after ptr, wrapping to port 0.
module wt_dcache_rr_pick #(
    parameter int unsigned NumPorts = 3,
    parameter int unsigned IdW      = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] i_req,
    input  logic [IdW-1:0]      i_ptr,
    output logic [IdW-1:0]      o_winner,
    output logic                o_any
);

    // Scan NumPorts positions starting at the pointer.
    always_comb begin
        int unsigned j;
        o_any    = 1'b0;
        o_winner = '0;
        j        = 0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            j = 32'(i_ptr) + i;
            if (j >= NumPorts) j = j - NumPorts;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_winner = IdW'(j);
            end
        end
    end

endmodule

// File: rtl/wt_dcache_rd_arb.sv
// Dcache read-port arbiter: round-robin grant, tag phase tracking,
// result steering and write-stall on read starvation.
module wt_dcache_rd_arb
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumPorts    = RD_ARB_PORTS,
    parameter int unsigned StarveLimit = 15
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumPorts-1:0]            rd_req_i,
    input  logic [NumPorts-1:0]            rd_tag_only_i,
    input  logic [NumPorts*CL_IDX_W-1:0]   rd_idx_i,
    input  logic [NumPorts*OFFSET_W-1:0]   rd_off_i,
    input  logic [NumPorts*TAG_W-1:0]      rd_tag_i,
    output logic [NumPorts-1:0]            rd_ack_o,
    output logic [NumPorts-1:0]            rd_vld_o,
    output logic [63:0]                    rd_data_o,
    output logic [DCACHE_SET_ASSOC-1:0]    rd_hit_oh_o,
    output logic [DCACHE_SET_ASSOC-1:0]    rd_vld_bits_o,
    output logic                           mem_rd_req_o,
    output logic                           mem_rd_tag_only_o,
    output logic [CL_IDX_W-1:0]            mem_rd_idx_o,
    output logic [OFFSET_W-1:0]            mem_rd_off_o,
    output logic [TAG_W-1:0]               mem_rd_tag_o,
    input  logic                           mem_rd_ack_i,
    input  logic [63:0]                    mem_rd_data_i,
    input  logic [DCACHE_SET_ASSOC-1:0]    mem_rd_hit_oh_i,
    input  logic [DCACHE_SET_ASSOC-1:0]    mem_rd_vld_bits_i,
    output logic                           stall_wr_o
);

    localparam int unsigned IdW  = $clog2(NumPorts);
    localparam int unsigned CntW = $clog2(StarveLimit + 1);

    logic [IdW-1:0]  ptr_q;
    logic [IdW-1:0]  gnt_id_q;
    logic            tag_ph_q;
    logic [CntW-1:0] cnt_q;
    logic            stall_q;

    logic [IdW-1:0]  w_win;
    logic            w_any;
    logic            w_ack;
    logic [IdW-1:0]  w_ptr_d;
    logic [CntW-1:0] w_cnt_d;
    logic [IdW-1:0]  w_tag_sel;

    dcache_rd_req_t    w_req [NumPorts];
    logic [TAG_W-1:0]  w_tag [NumPorts];

    wt_dcache_rr_pick #(
        .NumPorts (NumPorts),
        .IdW      (IdW)
    ) u_pick (
        .i_req    (rd_req_i),
        .i_ptr    (ptr_q),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    // Unpack the flat per-port buses.
    always_comb begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            w_req[p].tag_only = rd_tag_only_i[p];
            w_req[p].idx      = rd_idx_i[p*CL_IDX_W +: CL_IDX_W];
            w_req[p].off      = rd_off_i[p*OFFSET_W +: OFFSET_W];
            w_tag[p]          = rd_tag_i[p*TAG_W +: TAG_W];
        end
    end

    assign w_ack     = mem_rd_ack_i & w_any;
    assign w_ptr_d   = (w_win == IdW'(NumPorts - 1)) ? '0 : w_win + 1'b1;
    assign w_tag_sel = tag_ph_q ? gnt_id_q : w_win;

    // Refused-request counter, saturating at the stall threshold.
    always_comb begin
        w_cnt_d = '0;
        if (w_any && !mem_rd_ack_i) begin
            w_cnt_d = (cnt_q == CntW'(StarveLimit)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Request side toward memory and per-port ack/valid.
    always_comb begin
        mem_rd_req_o      = w_any;
        mem_rd_tag_only_o = w_req[w_win].tag_only;
        mem_rd_idx_o      = w_req[w_win].idx;
        mem_rd_off_o      = w_req[w_win].off;
        mem_rd_tag_o      = w_tag[w_tag_sel];
        rd_ack_o          = '0;
        rd_vld_o          = '0;
        if (w_ack)    rd_ack_o[w_win]    = 1'b1;
        if (tag_ph_q) rd_vld_o[gnt_id_q] = 1'b1;
    end

    assign rd_data_o     = mem_rd_data_i;
    assign rd_hit_oh_o   = mem_rd_hit_oh_i;
    assign rd_vld_bits_o = mem_rd_vld_bits_i;
    assign stall_wr_o    = stall_q;

    // Pointer, grant id, tag phase and starvation state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            gnt_id_q <= '0;
            tag_ph_q <= 1'b0;
            cnt_q    <= '0;
            stall_q  <= 1'b0;
        end else begin
            tag_ph_q <= w_ack;
            cnt_q    <= w_cnt_d;
            stall_q  <= (w_cnt_d == CntW'(StarveLimit));
            if (w_ack) begin
                ptr_q    <= w_ptr_d;
                gnt_id_q <= w_win;
            end
        end
    end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Randomized bench for wt_dcache_rd_arb.
// Outputs are compared mid-cycle against a queue-free rule model.
module tb_wt_dcache_rd_arb;
    import wt_cache_pkg::*;

    localparam int N   = 3;
    localparam int LIM = 15;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req, tonly;
    logic [N-1:0][CL_IDX_W-1:0] idx;
    logic [N-1:0][OFFSET_W-1:0] off;
    logic [N-1:0][TAG_W-1:0]    tag;
    logic        mack;
    logic [63:0] mdata;
    logic [DCACHE_SET_ASSOC-1:0] mhit, mvb;

    logic [N-1:0] ack_o, vld_o;
    logic [63:0]  data_o;
    logic [DCACHE_SET_ASSOC-1:0] hit_o, vb_o;
    logic         mreq_o, mto_o, stall_o;
    logic [CL_IDX_W-1:0] midx_o;
    logic [OFFSET_W-1:0] moff_o;
    logic [TAG_W-1:0]    mtag_o;

    wt_dcache_rd_arb #(.NumPorts(N), .StarveLimit(LIM)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .rd_req_i          (req),
        .rd_tag_only_i     (tonly),
        .rd_idx_i          (idx),
        .rd_off_i          (off),
        .rd_tag_i          (tag),
        .rd_ack_o          (ack_o),
        .rd_vld_o          (vld_o),
        .rd_data_o         (data_o),
        .rd_hit_oh_o       (hit_o),
        .rd_vld_bits_o     (vb_o),
        .mem_rd_req_o      (mreq_o),
        .mem_rd_tag_only_o (mto_o),
        .mem_rd_idx_o      (midx_o),
        .mem_rd_off_o      (moff_o),
        .mem_rd_tag_o      (mtag_o),
        .mem_rd_ack_i      (mack),
        .mem_rd_data_i     (mdata),
        .mem_rd_hit_oh_i   (mhit),
        .mem_rd_vld_bits_i (mvb),
        .stall_wr_o        (stall_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: next port to favour, last accepted port, refusal run length
    int m_next;
    bit m_pend;
    int m_pid;
    int m_refused;
    int m_wait [N];
    int m_acks [N];

    logic [N-1:0] s_ack, s_vld;
    logic         s_stall;
    logic [TAG_W-1:0] s_tag;

    task automatic chk(input string t, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", t, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_next = 0; m_pend = 0; m_pid = 0; m_refused = 0;
        for (int p = 0; p < N; p++) m_wait[p] = 0;
    endtask

    task automatic rand_payload();
        for (int p = 0; p < N; p++) begin
            idx[p] = CL_IDX_W'($urandom);
            off[p] = OFFSET_W'($urandom);
            tag[p] = TAG_W'($urandom);
        end
        tonly = N'($urandom);
        mdata = {$urandom, $urandom};
        mhit  = DCACHE_SET_ASSOC'($urandom);
        mvb   = DCACHE_SET_ASSOC'($urandom);
    endtask

    // one clock: compare mid-cycle, then advance the model across the edge
    task automatic cyc();
        bit any;
        int w;
        logic [N-1:0] ea, ev;
        logic [TAG_W-1:0] et;
        #4;
        any = 0; w = 0;
        for (int i = 0; i < N; i++) begin
            int j = (m_next + i) % N;
            if (!any && req[j]) begin any = 1; w = j; end
        end
        ea = '0; ev = '0;
        if (any && mack) ea[w] = 1'b1;
        if (m_pend) ev[m_pid] = 1'b1;
        et = m_pend ? tag[m_pid] : tag[w];
        s_ack = ack_o; s_vld = vld_o; s_stall = stall_o; s_tag = mtag_o;
        chk("ack", ack_o, ea);
        chk("vld", vld_o, ev);
        chk("ack_oh0", $onehot0(ack_o), 1);
        chk("vld_oh0", $onehot0(vld_o), 1);
        chk("mreq", mreq_o, any);
        chk("stall", stall_o, m_refused >= LIM);
        chk("data", data_o, mdata);
        chk("hit", hit_o, mhit);
        chk("vbits", vb_o, mvb);
        if (any || m_pend) chk("mtag", mtag_o, et);
        if (any) begin
            chk("midx", midx_o, idx[w]);
            chk("moff", moff_o, off[w]);
            chk("mto", mto_o, tonly[w]);
        end
        for (int p = 0; p < N; p++) begin
            if (req[p] && !(any && mack && w == p)) begin
                if (any && mack) m_wait[p]++;
            end else begin
                m_wait[p] = 0;
            end
            chk("wait_bound", m_wait[p] <= N, 1);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (any && mack) m_acks[w]++;
            m_pend = any && mack;
            if (m_pend) begin m_pid = w; m_next = (w + 1) % N; end
            if (any && !mack) m_refused = (m_refused < LIM) ? m_refused + 1 : LIM;
            else m_refused = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; mack = 1'b0;
        rand_payload();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] one;
        one = N'(1);
        rst = 1'b1; req = '0; mack = 1'b0;
        rand_payload();
        model_reset();
        for (int p = 0; p < N; p++) m_acks[p] = 0;
        @(posedge clk); #1;
        cyc();
        rst = 1'b0;
        rand_payload();
        cyc();
        chk("rst_ack", s_ack, 0);
        chk("rst_vld", s_vld, 0);
        chk("rst_stall", s_stall, 0);

        // continuous requests, rotating grant and tag phase
        do_reset();
        req = '1; mack = 1'b1;
        for (int k = 0; k < 7; k++) begin
            rand_payload();
            tag[1] = TAG_W'(20'hABC);
            cyc();
            chk("rr_seq", s_ack, one << (k % N));
            if (k > 0) chk("vld_seq", s_vld, one << ((k - 1) % N));
            if (k % N == 2) chk("tag_ph", s_tag, 20'hABC);
        end

        // starvation of a lone requester
        do_reset();
        req = 3'b100; mack = 1'b0;
        for (int k = 0; k < LIM; k++) begin
            rand_payload(); cyc();
            chk("stall_pre", s_stall, 0);
        end
        rand_payload(); cyc();
        chk("stall_on", s_stall, 1);
        mack = 1'b1;
        rand_payload(); cyc();
        chk("stall_ackcyc", s_stall, 1);
        chk("stall_ack", s_ack, 3'b100);
        req = '0; mack = 1'b0;
        rand_payload(); cyc();
        chk("stall_off", s_stall, 0);

        // withdrawal mid-retry
        do_reset();
        for (int p = 0; p < N; p++) m_acks[p] = 0;
        req = 3'b001; mack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_payload(); cyc();
            chk("wd_noack", s_ack, 0);
        end
        req = 3'b010; mack = 1'b1;
        rand_payload(); cyc();
        chk("wd_ack1", s_ack, 3'b010);
        req = '0; mack = 1'b0;
        rand_payload(); cyc();
        chk("wd_vld1", s_vld, 3'b010);
        chk("wd_p0_never", m_acks[0], 0);

        // reset during the tag phase
        do_reset();
        req = 3'b100; mack = 1'b1;
        rand_payload(); cyc();
        chk("rm_ack2", s_ack, 3'b100);
        rst = 1'b1; req = '1; mack = 1'b0;
        rand_payload(); cyc();
        chk("rm_vld_in_rst", s_vld, 3'b100);
        rst = 1'b0; mack = 1'b1;
        rand_payload(); cyc();
        chk("rm_vld_after", s_vld, 0);
        chk("rm_ptr0", s_ack, 3'b001);

        // random traffic
        for (int k = 0; k < 10000; k++) begin
            req  = N'($urandom);
            mack = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mack = 1'b0;
            rand_payload();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
